// File: rtl/laswp_engine.sv
// laswp_engine: LAPACK ?laswp row interchanges over one Avalon-MM master, one transaction in flight.
// Optional pivot range check under LASWP_BOUNDS_CHECK_EN; bus waits stretch each step, return held while stall.
module laswp_engine #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int ELEM_WORDS = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 stall,
  output logic [31:0]          returndata,
  input  logic signed [63:0]   n,
  input  logic [63:0]          a,
  input  logic signed [63:0]   lda,
  input  logic signed [63:0]   k1,
  input  logic signed [63:0]   k2,
  input  logic [63:0]          ipiv,
  input  logic signed [63:0]   incx,
  output logic [ADDR_W-1:0]    avm_address,
  output logic [DATA_W/8-1:0]  avm_byteenable,
  output logic                 avm_read,
  output logic                 avm_write,
  output logic [DATA_W-1:0]    avm_writedata,
  input  logic [DATA_W-1:0]    avm_readdata,
  input  logic                 avm_readdatavalid,
  input  logic                 avm_waitrequest
);
  localparam int BYTES   = DATA_W / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam int WW      = (ELEM_WORDS > 1) ? $clog2(ELEM_WORDS) : 1;
  localparam logic [WW-1:0]      W_LAST     = WW'(ELEM_WORDS - 1);
  localparam logic signed [63:0] EW         = 64'(ELEM_WORDS);
  localparam logic [63:0]        ALIGN_MASK = ~(64'(BYTES) - 64'd1);

  typedef enum logic [3:0] {
    IDLE, PIV_RD, PIV_WAIT, CHK, RD_A, RD_A_WAIT, RD_B, RD_B_WAIT, WR_A, WR_B, NEXT, DONE
  } state_t;
  state_t state;

  logic [63:0]        a_r, ipiv_r;
  logic signed [63:0] n_r, lda_r, incx_r, i_r, i_end, ix_r, ip_r, c_r, col_off;
  logic [WW-1:0]      w_r;
  logic [DATA_W-1:0]  buf_a;
  logic [15:0]        piv_sh;

  logic               early_exit, col_wrap, last_word;
  logic signed [63:0] ix0_in, nix, coff_nxt;
  logic [63:0]        piv_base, pb;
  logic [WW-1:0]      w_nxt;
  logic [31:0]        piv_lane;

  always_comb begin
    early_exit = (incx == 64'sd0) || (n <= 64'sd0) || (k2 < k1);
    ix0_in     = (incx > 64'sd0) ? k1 : 64'sd1 + (64'sd1 - k2) * incx;
    // The next pivot index: first entry on a call, otherwise the stepped one.
    nix        = (state == IDLE) ? ix0_in : ix_r + incx_r;
    piv_base   = (state == IDLE) ? ipiv : ipiv_r;
    pb         = piv_base + 64'((nix - 64'sd1) <<< 2);
    col_wrap   = (w_r == W_LAST);
    w_nxt      = col_wrap ? '0 : w_r + WW'(1);
    coff_nxt   = col_wrap ? col_off + lda_r : col_off;
    last_word  = col_wrap && (c_r == n_r);
    piv_lane   = 32'(avm_readdata >> piv_sh);
  end

  // col_off carries (c-1)*lda incrementally so no run-time multiply by lda is needed.
  function automatic logic [ADDR_W-1:0] elem_addr(input logic signed [63:0] row,
                                                   input logic signed [63:0] coff,
                                                   input logic [WW-1:0] w);
    logic signed [63:0] idx;
    idx = ((row - 64'sd1) + coff) * EW + $signed(64'(w));
    return ADDR_W'(a_r + 64'(idx <<< BYTE_SH));
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      returndata     <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      a_r            <= '0;
      ipiv_r         <= '0;
      n_r            <= '0;
      lda_r          <= '0;
      incx_r         <= '0;
      i_r            <= '0;
      i_end          <= '0;
      ix_r           <= '0;
      ip_r           <= '0;
      c_r            <= '0;
      col_off        <= '0;
      w_r            <= '0;
      buf_a          <= '0;
      piv_sh         <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r    <= a;
          ipiv_r <= ipiv;
          n_r    <= n;
          lda_r  <= lda;
          incx_r <= incx;
          busy   <= 1'b1;
          if (early_exit) begin
            state      <= DONE;
            done       <= 1'b1;
            returndata <= '0;
          end else begin
            i_r            <= (incx > 64'sd0) ? k1 : k2;
            i_end          <= (incx > 64'sd0) ? k2 : k1;
            ix_r           <= ix0_in;
            avm_address    <= ADDR_W'(pb & ALIGN_MASK);
            piv_sh         <= 16'((pb & ~ALIGN_MASK & ~64'd3) << 3);
            avm_read       <= 1'b1;
            avm_byteenable <= '1;
            state          <= PIV_RD;
          end
        end
        PIV_RD: if (!avm_waitrequest) begin
          avm_read       <= 1'b0;
          avm_byteenable <= '0;
          state          <= PIV_WAIT;
        end
        PIV_WAIT: if (avm_readdatavalid) begin
          ip_r  <= {{32{piv_lane[31]}}, piv_lane};
          state <= CHK;
        end
        CHK: begin
`ifdef LASWP_BOUNDS_CHECK_EN
          if (ip_r < 64'sd1 || ip_r > lda_r) begin
            state      <= DONE;
            done       <= 1'b1;
            returndata <= i_r[31:0];
          end else
`endif
          if (ip_r == i_r) begin
            state <= NEXT;
          end else begin
            c_r            <= 64'sd1;
            w_r            <= '0;
            col_off        <= '0;
            avm_address    <= elem_addr(i_r, 64'sd0, '0);
            avm_read       <= 1'b1;
            avm_byteenable <= '1;
            state          <= RD_A;
          end
        end
        RD_A: if (!avm_waitrequest) begin
          avm_read       <= 1'b0;
          avm_byteenable <= '0;
          state          <= RD_A_WAIT;
        end
        RD_A_WAIT: if (avm_readdatavalid) begin
          buf_a          <= avm_readdata;
          avm_address    <= elem_addr(ip_r, col_off, w_r);
          avm_read       <= 1'b1;
          avm_byteenable <= '1;
          state          <= RD_B;
        end
        RD_B: if (!avm_waitrequest) begin
          avm_read       <= 1'b0;
          avm_byteenable <= '0;
          state          <= RD_B_WAIT;
        end
        RD_B_WAIT: if (avm_readdatavalid) begin
          avm_writedata  <= avm_readdata;
          avm_address    <= elem_addr(i_r, col_off, w_r);
          avm_write      <= 1'b1;
          avm_byteenable <= '1;
          state          <= WR_A;
        end
        WR_A: if (!avm_waitrequest) begin
          avm_writedata <= buf_a;
          avm_address   <= elem_addr(ip_r, col_off, w_r);
          state         <= WR_B;
        end
        WR_B: if (!avm_waitrequest) begin
          avm_write <= 1'b0;
          if (last_word) begin
            avm_byteenable <= '0;
            state          <= NEXT;
          end else begin
            w_r         <= w_nxt;
            col_off     <= coff_nxt;
            c_r         <= col_wrap ? c_r + 64'sd1 : c_r;
            avm_address <= elem_addr(i_r, coff_nxt, w_nxt);
            avm_read    <= 1'b1;
            state       <= RD_A;
          end
        end
        NEXT: begin
          if (i_r == i_end) begin
            state      <= DONE;
            done       <= 1'b1;
            returndata <= '0;
          end else begin
            i_r            <= (incx_r > 64'sd0) ? i_r + 64'sd1 : i_r - 64'sd1;
            ix_r           <= nix;
            avm_address    <= ADDR_W'(pb & ALIGN_MASK);
            piv_sh         <= 16'((pb & ~ALIGN_MASK & ~64'd3) << 3);
            avm_read       <= 1'b1;
            avm_byteenable <= '1;
            state          <= PIV_RD;
          end
        end
        DONE: if (!stall) begin
          done       <= 1'b0;
          busy       <= 1'b0;
          returndata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_laswp_engine.sv
// Table-driven bench for laswp_engine: 4x3 complex matrix in a word memory behind a randomisable Avalon responder.
module tb_laswp_engine;
  localparam logic [63:0] A_BASE = 64'h400;
  localparam logic [63:0] P_BASE = 64'h100;

  logic               clock, reset, start, stall;
  logic               busy, done;
  logic [31:0]        returndata;
  logic signed [63:0] n, lda, k1, k2, incx;
  logic [63:0]        a, ipiv;
  logic [63:0]        avm_address;
  logic [7:0]         avm_byteenable;
  logic               avm_read, avm_write;
  logic [63:0]        avm_writedata, avm_readdata;
  logic               avm_readdatavalid, avm_waitrequest;

  laswp_engine #(.DATA_W(64), .ADDR_W(64), .ELEM_WORDS(2)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .stall(stall),
    .returndata(returndata), .n(n), .a(a), .lda(lda), .k1(k1), .k2(k2), .ipiv(ipiv), .incx(incx),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_read(avm_read),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
  );

  typedef struct {
    longint      n, k1, k2, incx;
    int          p0, p1, p2;
    bit          bp;
    logic [31:0] ret;
    int          cyc, rd, wr;
    logic [15:0] perm;     // nibble r (MSB first) = original row now held in row r
    bit          chk_mem;
    logic [63:0] pf, pl;
  } vec_t;

  vec_t        vecs [8];
  vec_t        exp_q [$];
  logic [63:0] mem [0:511];
  int          tests, fails;
  int          rd_cnt, wr_cnt, piv_cnt, stab_err, be_err;
  logic [63:0] piv_first, piv_last;
  bit          bp;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] enc(input int r, input int c, input int w);
    return 64'hA5A5_0000_0000_0000 | (64'(r) << 16) | (64'(c) << 8) | 64'(w);
  endfunction

  function automatic int widx(input int r, input int c, input int w);
    return int'(A_BASE >> 3) + ((r - 1) + (c - 1) * 4) * 2 + w;
  endfunction

  function automatic int perm_of(input logic [15:0] p, input int r);
    return int'(p[(4 - r) * 4 +: 4]);
  endfunction

  function automatic string tag(input int t, input string s);
    return $sformatf("v%0d %s", t, s);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic init_mem(input vec_t v);
    for (int i = 0; i < 512; i++) mem[i] = {32'hDEAD_0000, 32'(i)};
    for (int r = 1; r <= 4; r++)
      for (int c = 1; c <= 3; c++)
        for (int w = 0; w < 2; w++) mem[widx(r, c, w)] = enc(r, c, w);
    mem[int'(P_BASE >> 3)]     = {32'(v.p1), 32'(v.p0)};
    mem[int'(P_BASE >> 3) + 1] = {32'h0, 32'(v.p2)};
  endtask

  // Avalon slave: one command in flight, read latency 1 (or 1..5 with backpressure).
  initial begin : responder
    logic        acc_rd, acc_wr, p_wait, p_rd, p_wr;
    logic [63:0] cap_addr, cap_wdata, p_addr, p_wdata, pend_dat;
    int          pend;
    pend = 0; p_wait = 1'b0; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0; pend_dat = '0;
    avm_readdatavalid = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0;
    forever begin
      @(negedge clock);
      acc_rd    = avm_read && !avm_waitrequest;
      acc_wr    = avm_write && !avm_waitrequest;
      cap_addr  = avm_address;
      cap_wdata = avm_writedata;
      if (!reset && p_wait && (p_rd || p_wr) &&
          ({avm_read, avm_write, avm_address, avm_writedata} !== {p_rd, p_wr, p_addr, p_wdata}))
        stab_err++;
      if ((avm_read || avm_write) ? (avm_byteenable !== 8'hFF) : (avm_byteenable !== 8'h00))
        be_err++;
      p_wait = avm_waitrequest; p_rd = avm_read; p_wr = avm_write;
      p_addr = avm_address; p_wdata = avm_writedata;
      @(posedge clock);
      #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = {$urandom, $urandom};
      if (reset) begin
        pend = 0;
      end else begin
        if (acc_wr) begin
          mem[cap_addr[11:3]] = cap_wdata;
          wr_cnt++;
        end
        if (acc_rd) begin
          rd_cnt++;
          pend     = bp ? int'($urandom_range(1, 5)) : 1;
          pend_dat = mem[cap_addr[11:3]];
          if (cap_addr < A_BASE) begin
            if (piv_cnt == 0) piv_first = cap_addr;
            piv_last = cap_addr;
            piv_cnt++;
          end
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_dat;
          end
        end
      end
      avm_waitrequest = bp ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic run_call(input int t, input bit poke);
    vec_t v, e;
    int   cyc, bad;
    bit   seen;
    v = vecs[t];
    init_mem(v);
    bp = v.bp; rd_cnt = 0; wr_cnt = 0; piv_cnt = 0; stab_err = 0; be_err = 0;
    piv_first = '0; piv_last = '0;
    @(negedge clock);
    n = v.n; a = A_BASE; lda = 64'sd4; k1 = v.k1; k2 = v.k2; ipiv = P_BASE; incx = v.incx;
    stall = 1'b1; start = 1'b1;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 1;
    check(tag(t, "busy after start"), busy, 1'b1);
    seen = done;
    while (!seen && cyc < 5000) begin
      if (poke && cyc == 10) begin
        start = 1'b1; incx = 64'sd0; n = 64'sd0;
      end else if (poke && cyc == 11) begin
        start = 1'b0; incx = v.incx; n = v.n;
      end
      @(posedge clock);
      #1;
      cyc++;
      seen = done;
    end
    e = exp_q.pop_front();
    check(tag(t, "done within cycle budget"), seen, 1'b1);
    if (seen) begin
      if (e.cyc > 0) check(tag(t, "cycles start->done"), cyc, e.cyc);
      check(tag(t, "returndata"), returndata, e.ret);
      repeat (2) begin
        @(posedge clock);
        #1;
      end
      check(tag(t, "done held while stall"), {busy, done, returndata}, {1'b1, 1'b1, e.ret});
      @(negedge clock);
      stall = 1'b0;
      @(posedge clock);
      #1;
      check(tag(t, "busy/done drop after consume"), {busy, done}, 2'b00);
    end else begin
      @(negedge clock); reset = 1'b1;
      @(negedge clock); reset = 1'b0; stall = 1'b0;
    end
    check(tag(t, "read count"), rd_cnt, e.rd);
    check(tag(t, "write count"), wr_cnt, e.wr);
    check(tag(t, "outputs moved during wait"), stab_err, 0);
    check(tag(t, "byteenable errors"), be_err, 0);
    if (e.rd > 0) begin
      check(tag(t, "first pivot address"), piv_first, e.pf);
      check(tag(t, "last pivot address"), piv_last, e.pl);
    end
    if (e.chk_mem) begin
      bad = 0;
      for (int r = 1; r <= 4; r++)
        for (int c = 1; c <= 3; c++)
          for (int w = 0; w < 2; w++)
            if (mem[widx(r, c, w)] !== enc(perm_of(e.perm, r), c, w)) bad++;
      check(tag(t, "matrix words wrong"), bad, 0);
    end
  endtask

  initial begin : main
    int cyc;
    tests = 0; fails = 0; bp = 1'b0;
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    n = '0; a = '0; lda = '0; k1 = '0; k2 = '0; ipiv = '0; incx = '0;

    //            n  k1 k2 incx  p0 p1 p2 bp ret cyc  rd  wr  perm     mem pf      pl
    vecs[0] = '{4, 1, 3,  0,   3, 3, 4, 0, 0,   1,  0,  0, 16'h1234, 1, 64'h0,   64'h0};
    vecs[1] = '{3, 1, 3,  1,   3, 3, 4, 0, 0, 121, 39, 36, 16'h3142, 1, 64'h100, 64'h108};
    vecs[2] = '{3, 1, 3, -1,   3, 3, 4, 0, 0, 121, 39, 36, 16'h2413, 1, 64'h108, 64'h100};
    vecs[3] = '{3, 1, 3,  1,   3, 3, 4, 1, 0,   0, 39, 36, 16'h3142, 1, 64'h100, 64'h108};
    vecs[4] = '{3, 1, 3, -1,   3, 3, 4, 1, 0,   0, 39, 36, 16'h2413, 1, 64'h108, 64'h100};
    vecs[5] = '{3, 1, 3,  1,   1, 2, 3, 0, 0,  13,  3,  0, 16'h1234, 1, 64'h100, 64'h108};
    vecs[6] = '{3, 3, 1,  1,   3, 3, 4, 0, 0,   1,  0,  0, 16'h1234, 1, 64'h0,   64'h0};
`ifdef LASWP_BOUNDS_CHECK_EN
    vecs[7] = '{3, 1, 2,  1,   2, 9, 0, 0, 2,  44, 14, 12, 16'h2134, 1, 64'h100, 64'h100};
`else
    vecs[7] = '{3, 1, 2,  1,   2, 9, 0, 0, 0,  81, 26, 24, 16'h2134, 0, 64'h100, 64'h100};
`endif

    repeat (3) @(posedge clock);
    #1;
    check("reset busy/done", {busy, done}, 2'b00);
    check("reset returndata", returndata, 32'h0);
    check("reset read/write", {avm_read, avm_write}, 2'b00);
    check("reset byteenable", avm_byteenable, 8'h00);
    check("reset address", avm_address, 64'h0);
    check("reset writedata", avm_writedata, 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int t = 0; t < 8; t++) run_call(t, 1'b0);

    // Reset while the first WR_A is on the bus, then a fresh call that also sees a stray start.
    init_mem(vecs[1]);
    bp = 1'b0;
    @(negedge clock);
    n = vecs[1].n; a = A_BASE; lda = 64'sd4; k1 = vecs[1].k1; k2 = vecs[1].k2;
    ipiv = P_BASE; incx = vecs[1].incx; stall = 1'b1; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 0;
    while (!avm_write && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    check("reached first write", avm_write, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid-op reset outputs",
          {busy, done, returndata, avm_read, avm_write, avm_byteenable, avm_address},
          '0);
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clock);
    run_call(1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/laswp_engine.md
# laswp_engine

Parametrised row-interchange engine for LAPACK `?laswp`. It applies the pivot sequence `ipiv[k1..k2]` to an `n`-column, column-major matrix held in memory, reached through one Avalon-MM master. It is the generalised successor of the fixed complex-double swapper: element width is a parameter, words per element are a parameter, the bus handshake is full (waitrequest plus readdatavalid), and pivot-range checking is optional. It sits as a leaf accelerator behind the HLS call/return interface.

## Interface
Parameters:
- `DATA_W`, 64: bus data width in bits; must be a power of 2 and ≥ 32.
- `ADDR_W`, 64: byte address width.
- `ELEM_WORDS`, 2: bus words per matrix element.
  - 1 = real.
  - 2 = complex.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: call valid; sampled only in IDLE.
- `busy` out 1: call stall; high while not in IDLE.
- `done` out 1: return valid.
- `stall` in 1: return stall from the consumer.
- `returndata` out 32: 0 = success; otherwise the failing 1-based row index.
- `n`, `a`, `lda`, `k1`, `k2`, `ipiv`, `incx` in 64 each: call arguments.
  - `n`, `lda`, `k1`, `k2`, `incx` are signed.
  - `a` and `ipiv` are byte addresses.
- `avm_address` out `ADDR_W`: word-aligned byte address.
- `avm_byteenable` out `DATA_W/8`: always all-ones.
- `avm_read`, `avm_write` out 1 each.
- `avm_writedata` out `DATA_W`.
- `avm_readdata` in `DATA_W`.
- `avm_readdatavalid` in 1.
- `avm_waitrequest` in 1.

## Operation
- All arguments are latched on the cycle `start` is accepted.
- `incx==0`, `n<=0` or `k2<k1`: go directly to DONE with `returndata=0`; no bus traffic.
- Row order:
  - `incx>0`: `i = k1` up to `k2`; `ix0 = k1`.
  - `incx<0`: `i = k2` down to `k1`; `ix0 = 1 + (1-k2)*incx`.
  - `ix` steps by `incx` per row.
- Pivot entries are 32-bit signed integers, 1-based.
  - Entry address: `ipiv + (ix-1)*4`.
  - The word-aligned address is issued; the lane is selected by the low address bits.
- Element word address for 1-based row `r`, column `c`, word `w`: `a + (((r-1)+(c-1)*lda)*ELEM_WORDS + w)*(DATA_W/8)`.
  - Arithmetic is 64-bit signed; the result is truncated to `ADDR_W`.
- States:
  - IDLE → PIV_RD on `start`.
  - PIV_RD: assert `avm_read` until `!avm_waitrequest`, then → PIV_WAIT.
  - PIV_WAIT: wait for `avm_readdatavalid`, capture `ip`, then → CHK.
  - CHK: if `ip==i`, → NEXT (no swap). Otherwise → RD_A with `c=1`, `w=0`.
  - RD_A: read word `(i,c,w)` into `bufA` (issue, then wait for valid).
  - RD_B: read word `(ip,c,w)` into `bufB`.
  - WR_A: write `bufB` to `(i,c,w)`.
  - WR_B: write `bufA` to `(ip,c,w)`.
  - After WR_B: advance `w`, then `c`. When the last word of column `n` is written, → NEXT.
  - NEXT: advance `i` and `ix`. If the row range is exhausted, → DONE; otherwise → PIV_RD.
  - DONE: hold `done=1` and `returndata` until the cycle with `stall==0`, then → IDLE.
- Only one bus transaction is outstanding at any time.
  - `avm_address`, `avm_writedata`, `avm_read` and `avm_write` stay stable while `avm_waitrequest` is high.
  - `readdatavalid` outside a wait state is ignored.

## Timing
- Reset value of every output is 0. `avm_byteenable` also resets to 0 and drives all-ones only while `avm_read` or `avm_write` is high.
- Reset mid-operation: immediate return to IDLE. Any in-flight transaction is abandoned, and a late `readdatavalid` is ignored.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done` is consumed.
- Zero-wait bus with read data valid 1 cycle after the command:
  - 2 cycles per pivot read, plus 1 for CHK and 1 for NEXT.
  - 6 cycles per element word swapped (RD 2, RD 2, WR 1, WR 1).
  - Each `avm_waitrequest` cycle and each extra read-latency cycle adds exactly 1 cycle.
- Early exit: `done` asserts 1 cycle after `start`.
- `start` while busy is ignored.

## Configuration
- `LASWP_BOUNDS_CHECK_EN` defined: CHK additionally tests `1 <= ip <= lda`.
  - On violation: no swap for that row, immediate → DONE with `returndata = i[31:0]`.
  - Earlier completed swaps stay committed.
- Not defined: no check. `ip` is used unchecked and `returndata` is always 0.

## Test plan
- Early exit: `incx=0`, `n=4` → `done` 1 cycle after `start`, `returndata=0`, zero bus cycles.
- Forward pivots, complex case:
  - Setup: `ELEM_WORDS=2`, `n=3`, `lda=4`, `k1=1`, `k2=3`, `incx=1`, `ipiv={3,3,4}`.
  - Response: rows permuted as LAPACK reference; 3 swaps × 3 cols × 2 words = 72 data transactions.
  - Zero-wait cycle count matches the Timing rules exactly.
- Reverse order: `incx=-1` with the same `ipiv` → result equals the inverse permutation; pivot reads at descending addresses.
- Backpressure: random `avm_waitrequest` (50%) and read latency 1–5 → memory identical to the zero-wait run; bus outputs stable during every wait cycle.
- Identity pivots: `ipiv={1,2,3}` → only 3 pivot reads, no data traffic.
- Out-of-range pivot (`LASWP_BOUNDS_CHECK_EN`): `ipiv={2,9}`, `lda=4` → row-1 swap done, then `returndata=2`. Without the macro: `returndata=0`.
- Reset mid-operation: assert `reset` during WR_A → all outputs 0 next cycle; a fresh call then completes correctly.
